// File: rtl/smult_pkg.sv
// Shared types and constants for the smult_seq sequential radix-2 Booth multiplier.
// Holds the controller state enum, the Booth recode encodings and the default operand width.
package smult_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Recode of {multiplier LSB, previously shifted-out bit}.
  typedef enum logic [1:0] {
    BOOTH_NOP_0 = 2'b00,
    BOOTH_ADD   = 2'b01,
    BOOTH_SUB   = 2'b10,
    BOOTH_NOP_1 = 2'b11
  } booth_op_e;

  function automatic booth_op_e booth_recode(input logic q_lsb, input logic q_m1);
    return booth_op_e'({q_lsb, q_m1});
  endfunction

endpackage

// File: rtl/smult_booth_step.sv
// One combinational radix-2 Booth step: recode the bit pair, add/subtract the multiplicand
// into the upper accumulator half, then arithmetic-shift the whole accumulator right by one.
module smult_booth_step
  import smult_pkg::*;
#(
  parameter int  WIDTH    = DEFAULT_WIDTH,
  localparam int OUTWIDTH = 2 * WIDTH
) (
  input  logic [OUTWIDTH:0] acc_i,
  input  logic              q_m1_i,
  input  logic [WIDTH-1:0]  mcand_i,
  output logic [OUTWIDTH:0] acc_o,
  output logic              q_m1_o
);

  logic [WIDTH:0] hi;
  logic [WIDTH:0] mcand_ext;
  logic [WIDTH:0] sum;
  booth_op_e      op;

  always_comb begin
    hi        = acc_i[OUTWIDTH:WIDTH];
    mcand_ext = {mcand_i[WIDTH-1], mcand_i};
    op        = booth_recode(acc_i[0], q_m1_i);
    // NOTE: the default arm assigns sum on every path, so no latch is inferred.
    case (op)
      BOOTH_ADD: sum = hi + mcand_ext;
      BOOTH_SUB: sum = hi - mcand_ext;
      default:   sum = hi;
    endcase
    acc_o  = {sum[WIDTH], sum, acc_i[WIDTH-1:1]};
    q_m1_o = acc_i[0];
  end

endmodule

// File: rtl/smult_seq.sv
// Sequential signed multiplier, one Booth step per clock, valid/ready on both sides.
// Optional approximate mode: define SMULT_TRUNC_EN to zero the low TRUNC_BITS bits of P.
module smult_seq
  import smult_pkg::*;
#(
  parameter int  WIDTH      = DEFAULT_WIDTH,
  parameter int  TRUNC_BITS = 8,
  localparam int OUTWIDTH   = 2 * WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    IN1,
  input  logic [WIDTH-1:0]    IN2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUTWIDTH-1:0] P,
  output logic                busy
);

  localparam int              CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e              state_q;
  logic [OUTWIDTH:0]   acc_q, acc_d;
  logic                q_m1_q, q_m1_d;
  logic [WIDTH-1:0]    mcand_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [OUTWIDTH-1:0] p_q, p_d;
  logic                out_valid_q;
  logic                busy_q;
  logic                accept;

  smult_booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .q_m1_i  (q_m1_q),
    .mcand_i (mcand_q),
    .acc_o   (acc_d),
    .q_m1_o  (q_m1_d)
  );

`ifdef SMULT_TRUNC_EN
  localparam logic [OUTWIDTH-1:0] KEEP_MASK = {OUTWIDTH{1'b1}} << TRUNC_BITS;
  assign p_d = acc_d[OUTWIDTH-1:0] & KEEP_MASK;
`else
  assign p_d = acc_d[OUTWIDTH-1:0];
`endif

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign P         = p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset too, so P reads 0 and no stale operand survives reset.
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      q_m1_q      <= 1'b0;
      mcand_q     <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        CALC: begin
          acc_q  <= acc_d;
          q_m1_q <= q_m1_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_q     <= DONE;
            p_q         <= p_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      // NOTE: non-blocking updates let an accept here override the DONE->IDLE choice made above.
      if (accept) begin
        state_q <= CALC;
        busy_q  <= 1'b1;
        cnt_q   <= '0;
        acc_q   <= {{(WIDTH + 1){1'b0}}, IN2};
        q_m1_q  <= 1'b0;
        mcand_q <= IN1;
      end
    end
  end

endmodule

// File: tb/tb_smult_seq.sv
// Self-checking bench for smult_seq (WIDTH=16): directed corners, backpressure, reset abort,
// then randomized traffic scored against a plain-arithmetic signed product model.
module tb_smult_seq;

  localparam int W     = 16;
  localparam int OW    = 2 * W;
  localparam int TRUNC = 8;
  localparam int N_OPS = 400;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  IN1       = '0;
  logic [W-1:0]  IN2       = '0;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [OW-1:0] P;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [OW-1:0] exp_q[$];
  logic [W-1:0]  ra, rb;
  int            got_n, cyc, waits;
  logic          rdy_pick, stall;

  always #5 clk = ~clk;

  smult_seq #(.WIDTH(W), .TRUNC_BITS(TRUNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .IN1       (IN1),
    .IN2       (IN2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [OW-1:0] approx(input logic [OW-1:0] exact);
`ifdef SMULT_TRUNC_EN
    return (exact >> TRUNC) << TRUNC;
`else
    return exact;
`endif
  endfunction

  function automatic logic [OW-1:0] model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    longint prod;
    prod = longint'(a) * longint'(b);
    return approx(prod[OW-1:0]);
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Offers a pair and returns at the falling edge right after the accepting rising edge.
  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    IN1 = a;
    IN2 = b;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("offer_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    IN1 = W'($urandom);
    IN2 = W'($urandom);
  endtask

  task automatic wait_result(input string tag, input logic [OW-1:0] exp);
    int lat, busy_n;
    lat = 0;
    busy_n = 0;
    while (!out_valid && lat < 64) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(W));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(W));
    check({tag, "_P"}, 64'(P), 64'(exp));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_in_ready", 64'(in_ready), 64'd1);
  endtask

  logic [W-1:0]  ca[4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h00FF};
  logic [W-1:0]  cb[4] = '{16'h8000, 16'h8000, 16'hFFFF, 16'h00FF};
  logic [OW-1:0] ce[4] = '{32'h4000_0000, 32'hC000_8000, 32'h0000_0000, 32'h0000_FE01};

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_P", 64'(P), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    offer(W'(3), W'(-5));
    wait_result("basic", approx(32'hFFFF_FFF1));
    drain();

    for (int i = 0; i < 4; i++) begin
      offer(ca[i], cb[i]);
      wait_result($sformatf("corner%0d", i), approx(ce[i]));
      drain();
    end

    offer(W'(-1234), W'(567));
    wait_result("bp", model(W'(-1234), W'(567)));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_P", 64'(P), 64'(model(W'(-1234), W'(567))));
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    IN1 = W'(7);
    IN2 = W'(7);
    #1 check("b2b_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    IN1 = W'($urandom);
    IN2 = W'($urandom);
    check("b2b_out_valid_drop", 64'(out_valid), 64'd0);
    check("b2b_busy", 64'(busy), 64'd1);
    wait_result("b2b", approx(32'd49));
    drain();

    offer(W'(5), W'(6));
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_P", 64'(P), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    IN1 = W'(2);
    IN2 = W'(2);
    @(negedge clk);
    in_valid = 1'b0;
    IN1 = W'($urandom);
    IN2 = W'($urandom);
    wait_result("post_rst", approx(32'd4));
    drain();

    got_n = 0;
    fork
      begin : drv
        for (int i = 0; i < N_OPS; i++) begin
          ra = pick();
          rb = pick();
          repeat ($urandom_range(0, 3)) @(negedge clk);
          @(negedge clk);
          in_valid = 1'b1;
          IN1 = ra;
          IN2 = rb;
          #1;
          waits = 0;
          while (!in_ready && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
          end
          if (!in_ready) begin
            check("rand_accept_timeout", 64'(in_ready), 64'd1);
            break;
          end
          exp_q.push_back(model(ra, rb));
          @(negedge clk);
          in_valid = 1'b0;
          IN1 = W'($urandom);
          IN2 = W'($urandom);
        end
        in_valid = 1'b0;
      end
      begin : mon
        cyc   = 0;
        stall = 1'b0;
        while (got_n < N_OPS && cyc < 30000) begin
          @(negedge clk);
          cyc++;
          if (stall) begin
            check("rand_hold_valid", 64'(out_valid), 64'd1);
            if (exp_q.size() > 0) check("rand_hold_P", 64'(P), 64'(exp_q[0]));
          end
          rdy_pick  = 1'($urandom_range(0, 1));
          out_ready = rdy_pick;
          if (out_valid && rdy_pick) begin
            if (exp_q.size() == 0) check("rand_unexpected_out", 64'(out_valid), 64'd0);
            else check("rand_P", 64'(P), 64'(exp_q.pop_front()));
            got_n++;
          end
          stall = out_valid && !rdy_pick;
        end
        if (got_n < N_OPS) check("rand_timeout", 64'(got_n), 64'(N_OPS));
        out_ready = 1'b0;
      end
    join

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
